fp_f2d_arbiter: RTL

// - Shares one f2d (FP32->FP64) converter between NUM_REQ requesters, e.g. issue lanes.
// - Round-robin grant; one request converted per cycle; results go to an output FIFO

---
 rtl/fp_f2d_arbiter_pkg.sv | 69 ++++++
 rtl/fp_f2d_arbiter_rr.sv | 40 ++++
 rtl/fp_f2d_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/fp_f2d_arbiter_pkg.sv
// Shared types and the FP32 -> FP64 conversion used by the f2d arbiter.
package fp_f2d_arbiter_pkg;

    // IEEE exception flags in RISC-V fflags order (NV DZ OF UF NX).
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // FP64 result together with the exception flags raised while producing it.
    typedef struct packed {
        logic [63:0] value;
        fflags_t     flags;
    } round_res_t;

    // Requester ids are stored at this width; supports up to 16 requesters.
    localparam int F2D_ARB_IDW = 4;

    typedef struct packed {
        round_res_t             result;
        logic [F2D_ARB_IDW-1:0] id;
    } f2d_arb_entry_t;

    // FP32 -> FP64 widening is always exact, so only a signalling NaN raises a flag.
    // NaNs are quieted with their payload kept; FP32 denormals become FP64 normals.
    function automatic round_res_t f2d(input logic [31:0] op);
        logic        sign;
        logic [7:0]  expIn;
        logic [22:0] manIn;
        logic [4:0]  lead;
        logic [52:0] shifted;
        round_res_t  res;

        sign    = op[31];
        expIn   = op[30:23];
        manIn   = op[22:0];
        res     = '0;
        lead    = '0;
        shifted = '0;

        if (expIn == 8'hFF) begin
            if (manIn == 23'd0) begin
                res.value = {sign, 11'h7FF, 52'd0};
            end else begin
                res.value    = {sign, 11'h7FF, 1'b1, manIn[21:0], 29'd0};
                res.flags.nv = ~manIn[22];
            end
        end else if (expIn == 8'd0) begin
            if (manIn == 23'd0) begin
                res.value = {sign, 63'd0};
            end else begin
                for (int i = 0; i < 23; i++) begin
                    if (manIn[i]) begin
                        lead = 5'(i);
                    end
                end
                shifted   = {30'd0, manIn} << (6'd52 - {1'b0, lead});
                res.value = {sign, 11'd874 + {6'd0, lead}, shifted[51:0]};
            end
        end else begin
            res.value = {sign, {3'd0, expIn} + 11'd896, manIn, 29'd0};
        end
        return res;
    endfunction

endpackage

// File: rtl/fp_f2d_arbiter_rr.sv
// Round-robin arbiter: picks the first requester at or after ptr_i, wrapping at N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_oh_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          found_o
);

    // Walk candidates ptr, ptr+1, ... with explicit wrap so non-power-of-2 N never yields an illegal id.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] cand;
        logic          hit;

        grant_oh_o  = '0;
        grant_idx_o = '0;
        hit         = 1'b0;
        sum         = '0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (en_i && !hit && req_i[cand]) begin
                hit               = 1'b1;
                grant_idx_o       = cand;
                grant_oh_o[cand]  = 1'b1;
            end
        end
        found_o = hit;
    end

endmodule

// File: rtl/fp_f2d_arbiter.sv
// Shares one FP32->FP64 converter between NUM_REQ requesters; results queue in a
// small FIFO tagged with the requester id, and a sticky NV bit is kept per requester.
module fp_f2d_arbiter
    import fp_f2d_arbiter_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int FIFO_DEPTH = 2,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ-1:0][31:0] req_data_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output round_res_t              resp_result_o,
    output logic [IDW-1:0]          resp_id_o,
    output logic [NUM_REQ-1:0]      nv_sticky_o,
    input  logic [NUM_REQ-1:0]      nv_clear_i,
    output logic                    busy_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]      rd_q, rd_d;
    logic [PW-1:0]      wr_q, wr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [NUM_REQ-1:0] nv_q, nv_d;
    f2d_arb_entry_t     mem_q [FIFO_DEPTH];

    logic [NUM_REQ-1:0] grantOh;
    logic [IDW-1:0]     grantIdx;
    logic               found;
    round_res_t         convRes;
    f2d_arb_entry_t     pushEntry;
    logic               respValid;
    logic               full;
    logic               pop;
    logic               accept;

    rr_arbiter #(.N(NUM_REQ)) uArb (
        .req_i       (req_valid_i),
        .ptr_i       (ptr_q),
        .en_i        (1'b1),
        .grant_oh_o  (grantOh),
        .grant_idx_o (grantIdx),
        .found_o     (found)
    );

    // The single converter instance sees only the granted operand; ready never depends on data.
    assign convRes          = f2d(req_data_i[grantIdx]);
    assign pushEntry.result = convRes;
    assign pushEntry.id     = F2D_ARB_IDW'(grantIdx);

    assign respValid = (count_q != '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign pop       = respValid & resp_ready_i;
    assign accept    = found & (~full | pop);

    assign req_ready_o   = accept ? grantOh : '0;
    assign resp_valid_o  = respValid;
    assign busy_o        = respValid;
    assign resp_result_o = respValid ? mem_q[rd_q].result : '0;
    assign resp_id_o     = respValid ? mem_q[rd_q].id[IDW-1:0] : '0;
    assign nv_sticky_o   = nv_q;

    // Next-state for pointers, occupancy and sticky NV; a new NV set overrides a same-cycle clear.
    always_comb begin
        ptr_d   = ptr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        nv_d    = nv_q & ~nv_clear_i;
        if (accept) begin
            ptr_d = (grantIdx == IDW'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
            wr_d  = wr_q + 1'b1;
            if (convRes.flags.nv) begin
                nv_d[grantIdx] = 1'b1;
            end
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state register; reset empties the FIFO and restarts arbitration at requester 0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            nv_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            nv_q    <= nv_d;
        end
    end

    // FIFO storage needs no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q[wr_q] <= pushEntry;
        end
    end

endmodule
